// File: rtl/afe_spi_ctrl.sv
// AFE configuration master: power-up reset sequencing followed by single-register
// 16-bit SPI (mode 0, MSB first) write/read transactions on a cmd/rsp handshake.
module afe_spi_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 64,
  parameter int unsigned INIT_WAIT  = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       init_done,
  output logic       afe_reset,
  output logic       afe_spi_clk,
  output logic       afe_spi_mosi,
  output logic       afe_sen,
  input  logic       afe_spi_miso
);

  localparam int unsigned MAX_RI  = (RST_CYCLES > INIT_WAIT) ? RST_CYCLES : INIT_WAIT;
  localparam int unsigned CNT_MAX = (MAX_RI > CLK_DIV) ? MAX_RI : CLK_DIV;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    RST_HOLD, RST_WAIT, IDLE, XFER, SEN_HOLD, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          phase_q, phase_d;
  logic [15:0]   sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          rw_q, rw_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          init_done_q, init_done_d;
  logic          afe_reset_q, afe_reset_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          sen_q, sen_d;
  logic [15:0]   frame;

  assign frame = {cmd_rw, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};

  assign cmd_ready    = ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign init_done    = init_done_q;
  assign afe_reset    = afe_reset_q;
  assign afe_spi_clk  = sclk_q;
  assign afe_spi_mosi = mosi_q;
  assign afe_sen      = sen_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_d       = bit_q;
    phase_d     = phase_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    afe_reset_d = afe_reset_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    sen_d       = sen_q;

    unique case (state_q)
      RST_HOLD: if (cnt_q == RST_LAST) begin
        cnt_d       = '0;
        afe_reset_d = 1'b0;
        state_d     = RST_WAIT;
      end
      RST_WAIT: if (cnt_q == WAIT_LAST) begin
        cnt_d       = '0;
        init_done_d = 1'b1;
        ready_d     = 1'b1;
        state_d     = IDLE;
      end
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid && ready_q) begin
          sh_d    = {frame[14:0], 1'b0};
          mosi_d  = frame[15];
          rw_d    = cmd_rw;
          sen_d   = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          bit_d   = '0;
          phase_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: if (cnt_q == DIV_LAST) begin
        cnt_d = '0;
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          // end of high phase: sample MISO, then open the next bit's low phase
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          rx_d    = {rx_q[6:0], afe_spi_miso};
          if (bit_q == 4'd15) begin
            state_d = SEN_HOLD;
          end else begin
            bit_d  = bit_q + 4'd1;
            mosi_d = sh_q[15];
            sh_d   = {sh_q[14:0], 1'b0};
          end
        end
      end
      SEN_HOLD: if (cnt_q == DIV_LAST) begin
        cnt_d       = '0;
        sen_d       = 1'b1;
        rsp_valid_d = 1'b1;
        rdata_d     = rw_q ? rx_q : 8'h00;
        state_d     = GAP;
      end
      GAP: if (cnt_q == DIV_LAST) begin
        cnt_d   = '0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RST_HOLD;
      end
    endcase

    busy_d = !ready_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      sh_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
      afe_reset_q <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      sen_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
      afe_reset_q <= afe_reset_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      sen_q       <= sen_d;
    end
  end

endmodule
